sdram_arbiter: RTL and testbench

Two-port arbiter sharing the single Avalon-style master port of `sdram_controller` between the RX capture path (port 0, writes AFE samples) and the TX playback path (port 1, reads samples back). Sits between the sample FIFOs and `sdram_controller` in the `clk_main` domain. Provides bounded-burst arbitration, read-stall protection and in-order read-data routing to the requester that issued each read.

---
 rtl/sdram_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Shares the single Avalon-style master port of sdram_controller between the
// RX capture path (port 0, writes) and the TX playback path (port 1, reads).
// Arbitration happens in bursts. A tag FIFO remembers which port issued each
// outstanding read, so returning data is routed back to that port in order.
//
// Build option:
//   SDRAM_ARB_FIXED_PRIO_EN  defined   -> port 0 wins whenever it requests,
//                                         both from idle and at every release.
//                            undefined -> round-robin (default build).
//
// Ports:
//   clk, reset_n          clock (rising edge) / async active-low reset
//   pN_req/wr/addr/wdata  port N command, held until pN_ack
//   pN_ack                command accepted this cycle (combinational)
//   pN_rdata/pN_rvalid    registered read return, 1-cycle valid pulse
//   az_*                  command outputs to sdram_controller
//   za_data/za_valid      read return from sdram_controller
//   za_waitrequest        controller stall
//   rd_err                sticky: za_valid arrived with no read outstanding
// -----------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_BURST   = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  p0_req,
  input  logic                  p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_rvalid,
  input  logic                  p1_req,
  input  logic                  p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_rvalid,
  output logic [ADDR_WIDTH-1:0] az_addr,
  output logic [DATA_WIDTH-1:0] az_data,
  output logic [1:0]            az_be_n,
  output logic                  az_cs,
  output logic                  az_rd_n,
  output logic                  az_wr_n,
  input  logic [DATA_WIDTH-1:0] za_data,
  input  logic                  za_valid,
  input  logic                  za_waitrequest,
  output logic                  rd_err
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  // Ownership / burst state
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             last_p1_q;   // last owner was port 1 (round-robin memory)

  // Read tag FIFO
  logic             tag_mem_q [MAX_PENDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   pend_q;

  // Registered read return
  logic [DATA_WIDTH-1:0] p0_rdata_q, p1_rdata_q;
  logic                  p0_rvalid_q, p1_rvalid_q;
  logic                  rd_err_q;

  // Owner's command, muxed
  logic                  own_req, own_wr;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  other_req;

  logic cmd_valid, accept, release_ev, pend_full;
  logic push, pop, orphan, push_tag, pop_tag;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no latch can be inferred on an unlisted path.
    own_req   = 1'b0;
    own_wr    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    other_req = 1'b0;
    unique case (owner_q)
      OWN_P0: begin
        own_req   = p0_req;
        own_wr    = p0_wr;
        own_addr  = p0_addr;
        own_wdata = p0_wdata;
        other_req = p1_req;
      end
      OWN_P1: begin
        own_req   = p1_req;
        own_wr    = p1_wr;
        own_addr  = p1_addr;
        own_wdata = p1_wdata;
        other_req = p0_req;
      end
      default: ;
    endcase
  end

  assign pend_full  = (pend_q == (PTR_W+1)'(MAX_PENDING));
  // A read is held off (not stalled on the bus) while the tag FIFO is full.
  assign cmd_valid  = (owner_q != OWN_NONE) && own_req && !(!own_wr && pend_full);
  assign accept     = cmd_valid && !za_waitrequest;
  // A stalled command keeps own_req high and is not accepted, so it can
  // never trigger a release: ownership is frozen until the controller takes it.
  assign release_ev = !own_req || (accept && (burst_q == CNT_W'(MAX_BURST - 1)));

  // Next owner / burst counter
  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    if (owner_q == OWN_NONE) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      owner_d = p0_req ? OWN_P0 : (p1_req ? OWN_P1 : OWN_NONE);
`else
      if (p0_req && p1_req) owner_d = last_p1_q ? OWN_P0 : OWN_P1;
      else if (p0_req)      owner_d = OWN_P0;
      else if (p1_req)      owner_d = OWN_P1;
`endif
    end else if (release_ev) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      owner_d = p0_req ? OWN_P0 : (p1_req ? OWN_P1 : OWN_NONE);
`else
      if (other_req)    owner_d = (owner_q == OWN_P0) ? OWN_P1 : OWN_P0;
      else if (own_req) owner_d = owner_q;
      else              owner_d = OWN_NONE;
`endif
    end
    // A release that keeps the same owner still starts a fresh burst.
    if ((owner_d != owner_q) || release_ev) burst_d = '0;
    else if (accept)                        burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    if (!reset_n) begin
      owner_q   <= OWN_NONE;
      burst_q   <= '0;
      last_p1_q <= 1'b1;   // port 0 wins the first contended grant
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      if (owner_q != OWN_NONE) last_p1_q <= (owner_q == OWN_P1);
    end
  end

  // Command outputs
  assign az_cs   = cmd_valid;
  assign az_rd_n = cmd_valid ? own_wr  : 1'b1;
  assign az_wr_n = cmd_valid ? ~own_wr : 1'b1;
  assign az_addr = cmd_valid ? own_addr  : '0;
  assign az_data = cmd_valid ? own_wdata : '0;
  assign az_be_n = 2'b00;
  assign p0_ack  = accept && (owner_q == OWN_P0);
  assign p1_ack  = accept && (owner_q == OWN_P1);

  // Tag FIFO: one bit per outstanding read, 1 = port 1
  assign push     = accept && !own_wr;
  assign push_tag = (owner_q == OWN_P1);
  assign pop      = za_valid && (pend_q != '0);
  assign orphan   = za_valid && (pend_q == '0);
  assign pop_tag  = tag_mem_q[rd_ptr_q];

  // NOTE: tag storage has no reset; the reset pointers and count alone
  // decide which entries are live, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= push_tag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   pend_q <= pend_q - 1'b1;
        default: ;
      endcase
      p0_rvalid_q <= pop && !pop_tag;
      p1_rvalid_q <= pop && pop_tag;
      if (pop && !pop_tag) p0_rdata_q <= za_data;
      if (pop && pop_tag)  p1_rdata_q <= za_data;
      if (orphan)          rd_err_q   <= 1'b1;
    end
  end

  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Directed bench for sdram_arbiter (MAX_BURST=4, MAX_PENDING=8). Read returns
// are scoreboarded: each time za_valid is driven, the expected {port, data}
// is pushed; a negedge monitor pops and compares on every pN_rvalid.
// Works for both the round-robin and SDRAM_ARB_FIXED_PRIO_EN builds.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          p0_req, p0_wr, p1_req, p1_wr;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] az_addr;
  logic [DW-1:0] az_data;
  logic [1:0]    az_be_n;
  logic          az_cs, az_rd_n, az_wr_n;
  logic [DW-1:0] za_data;
  logic          za_valid, za_waitrequest;
  logic          rd_err;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t rd_exp[$];     // scoreboard of expected read returns
  logic    tag_model[$];  // issuing port of each accepted read, in order

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4),
    .MAX_PENDING(8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .p0_req        (p0_req),
    .p0_wr         (p0_wr),
    .p0_addr       (p0_addr),
    .p0_wdata      (p0_wdata),
    .p0_ack        (p0_ack),
    .p0_rdata      (p0_rdata),
    .p0_rvalid     (p0_rvalid),
    .p1_req        (p1_req),
    .p1_wr         (p1_wr),
    .p1_addr       (p1_addr),
    .p1_wdata      (p1_wdata),
    .p1_ack        (p1_ack),
    .p1_rdata      (p1_rdata),
    .p1_rvalid     (p1_rvalid),
    .az_addr       (az_addr),
    .az_data       (az_data),
    .az_be_n       (az_be_n),
    .az_cs         (az_cs),
    .az_rd_n       (az_rd_n),
    .az_wr_n       (az_wr_n),
    .za_data       (za_data),
    .za_valid      (za_valid),
    .za_waitrequest(za_waitrequest),
    .rd_err        (rd_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drive one za_valid return for the oldest outstanding read, then check the
  // rvalid pulse appears on the issuing port one cycle later.
  task automatic return_read(input logic [DW-1:0] d);
    logic    p;
    rd_exp_t e;
    p = tag_model.pop_front();
    e.port = p;
    e.data = d;
    rd_exp.push_back(e);
    za_valid = 1'b1;
    za_data  = d;
    tick();
    za_valid = 1'b0;
    za_data  = '0;
    settle();
    check($sformatf("ret_rvalid_p%0d_%0h", p, d), p ? p1_rvalid : p0_rvalid, 1'b1);
    check($sformatf("ret_rdata_p%0d_%0h", p, d), p ? p1_rdata : p0_rdata, d);
  endtask

  function automatic logic exp_p1_owner(input int c);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return ((c / 4) % 2) == 1;
`endif
  endfunction

  // Scoreboard monitor: every rvalid pulse must match the next expected return.
  always @(negedge clk) begin
    if (reset_n && (p0_rvalid || p1_rvalid)) begin
      if (rd_exp.size() == 0) begin
        check("rvalid_unexpected", {p1_rvalid, p0_rvalid}, 2'b00);
      end else begin
        rd_exp_t e;
        e = rd_exp.pop_front();
        check("sb_port", {p1_rvalid, p0_rvalid}, e.port ? 2'b10 : 2'b01);
        check("sb_data", e.port ? p1_rdata : p0_rdata, e.data);
      end
    end
  end

  initial begin
    logic e1;
    reset_n = 1'b0;
    p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;
    za_data = '0; za_valid = 0; za_waitrequest = 0;

    // ---- reset values ----
    repeat (3) tick();
    check("rst_az_cs",   az_cs,   1'b0);
    check("rst_az_rd_n", az_rd_n, 1'b1);
    check("rst_az_wr_n", az_wr_n, 1'b1);
    check("rst_az_addr", az_addr, 20'h0);
    check("rst_az_data", az_data, 16'h0);
    check("rst_az_be_n", az_be_n, 2'b00);
    check("rst_acks",    {p1_ack, p0_ack}, 2'b00);
    check("rst_rvalid",  {p1_rvalid, p0_rvalid}, 2'b00);
    check("rst_rdata",   {p1_rdata, p0_rdata}, 32'h0);
    check("rst_rd_err",  rd_err,  1'b0);
    reset_n = 1'b1;
    tick();

    // ---- contention: both write continuously, bursts of 4 ----
    p0_req = 1; p0_wr = 1; p0_addr = 20'h00100; p0_wdata = 16'hA0A0;
    p1_req = 1; p1_wr = 1; p1_addr = 20'h00200; p1_wdata = 16'hB1B1;
    settle();
    check("cont_no_ack_idle", {p1_ack, p0_ack}, 2'b00);
    tick();  // grant edge
    for (int c = 0; c < 12; c++) begin
      settle();
      e1 = exp_p1_owner(c);
      check($sformatf("cont_p0_ack_%0d", c), p0_ack, !e1);
      check($sformatf("cont_p1_ack_%0d", c), p1_ack, e1);
      check($sformatf("cont_addr_%0d", c), az_addr, e1 ? 20'h00200 : 20'h00100);
      tick();
    end
    p0_req = 0; p1_req = 0;
    settle();
    check("cont_drop_cs", az_cs, 1'b0);
    tick();

    // ---- single port 0: 5 writes 0x10..0x14 ----
    p0_req = 1; p0_wr = 1; p0_addr = 20'h00010; p0_wdata = 16'hD000;
    settle();
    check("p0w_idle_ack", p0_ack, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      p0_addr  = 20'h00010 + 20'(i);
      p0_wdata = 16'hD000 + 16'(i);
      settle();
      check($sformatf("p0w_ack_%0d", i),  p0_ack,  1'b1);
      check($sformatf("p0w_wr_n_%0d", i), {az_wr_n, az_rd_n}, 2'b01);
      check($sformatf("p0w_addr_%0d", i), az_addr, 20'h00010 + 20'(i));
      check($sformatf("p0w_data_%0d", i), az_data, 16'hD000 + 16'(i));
      tick();
    end
    p0_req = 0;
    settle();
    check("p0w_done_cs", az_cs, 1'b0);
    tick();

    // ---- waitrequest stall on a P1 read while P0 requests ----
    p1_req = 1; p1_wr = 0; p1_addr = 20'h00333;
    za_waitrequest = 1;
    tick();  // grant P1
    p0_req = 1; p0_wr = 1; p0_addr = 20'h00444; p0_wdata = 16'h4444;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("stall_cs_%0d", c),   {az_cs, az_rd_n}, 2'b10);
      check($sformatf("stall_addr_%0d", c), az_addr, 20'h00333);
      check($sformatf("stall_acks_%0d", c), {p1_ack, p0_ack}, 2'b00);
      tick();
    end
    za_waitrequest = 0;
    settle();
    check("stall_p1_ack_c4", {p1_ack, p0_ack}, 2'b10);
    check("stall_addr_c4", az_addr, 20'h00333);
    tag_model.push_back(1'b1);
    tick();
    p1_req = 0;
    settle();
    check("stall_handover_gap", {p1_ack, p0_ack}, 2'b00);
    tick();  // P1 releases, P0 takes over
    settle();
    check("stall_p0_ack", p0_ack, 1'b1);
    check("stall_p0_addr", az_addr, 20'h00444);
    tick();
    p0_req = 0;
    tick();
    return_read(16'h1234);

    // ---- P1 burst release hands ownership to waiting P0 ----
    p1_req = 1; p1_wr = 1; p1_addr = 20'h00700; p1_wdata = 16'h7777;
    tick();  // grant P1
    for (int c = 0; c < 4; c++) begin
      settle();
      check($sformatf("rel_p1_ack_%0d", c), {p1_ack, p0_ack}, 2'b10);
      tick();
      p0_req = 1; p0_wr = 1; p0_addr = 20'h00701; p0_wdata = 16'h0701;
    end
    settle();
    check("rel_p0_wins", {p1_ack, p0_ack}, 2'b01);
    tick();
    p0_req = 0; p1_req = 0;
    tick();

    // ---- pending limit: P1 issues reads, returns withheld ----
    p1_req = 1; p1_wr = 0; p1_addr = 20'h00500;
    settle();
    check("pend_idle_ack", p1_ack, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      p1_addr = 20'h00500 + 20'(i);
      settle();
      check($sformatf("pend_ack_%0d", i), p1_ack, 1'b1);
      check($sformatf("pend_rd_n_%0d", i), az_rd_n, 1'b0);
      tag_model.push_back(1'b1);
      tick();
    end
    p1_addr = 20'h00508;
    settle();
    check("pend_full_ack", p1_ack, 1'b0);
    check("pend_full_cs", az_cs, 1'b0);
    tick();
    settle();
    check("pend_full_cs_held", {az_cs, p1_ack}, 2'b00);
    return_read(16'h9000);
    check("pend_slot_freed_ack", p1_ack, 1'b1);
    tag_model.push_back(1'b1);
    tick();
    p1_addr = 20'h00509;
    settle();
    check("pend_full_again", {az_cs, p1_ack}, 2'b00);
    p1_req = 0;
    tick();
    for (int i = 0; i < 8; i++) return_read(16'h9001 + 16'(i));

    // ---- mixed routing: P0 read then P1 read ----
    p0_req = 1; p0_wr = 0; p0_addr = 20'h00100;
    tick();
    settle();
    check("mix_p0_ack", p0_ack, 1'b1);
    tag_model.push_back(1'b0);
    tick();
    p0_req = 0;
    p1_req = 1; p1_wr = 0; p1_addr = 20'h00200;
    settle();
    check("mix_gap", {p1_ack, p0_ack}, 2'b00);
    tick();
    settle();
    check("mix_p1_ack", p1_ack, 1'b1);
    check("mix_p1_addr", az_addr, 20'h00200);
    tag_model.push_back(1'b1);
    tick();
    p1_req = 0;
    tick();
    return_read(16'hAAAA);
    return_read(16'h5555);

    // ---- orphan za_valid ----
    check("orphan_pre", rd_err, 1'b0);
    za_valid = 1; za_data = 16'hDEAD;
    tick();
    za_valid = 0;
    settle();
    check("orphan_rd_err", rd_err, 1'b1);
    tick();
    check("orphan_sticky", rd_err, 1'b1);

    // ---- reset mid-burst with a read outstanding ----
    p0_req = 1; p0_wr = 0; p0_addr = 20'h00600;
    tick();
    settle();
    check("mr_read_ack", p0_ack, 1'b1);
    tick();
    p0_wr = 1; p0_addr = 20'h00601; p0_wdata = 16'h6666;
    settle();
    check("mr_write_ack", {az_cs, p0_ack}, 2'b11);
    reset_n = 0;
    settle();
    check("mr_az_cs",   az_cs, 1'b0);
    check("mr_strobes", {az_rd_n, az_wr_n}, 2'b11);
    check("mr_addr",    az_addr, 20'h0);
    check("mr_data",    az_data, 16'h0);
    check("mr_ack",     p0_ack, 1'b0);
    check("mr_rd_err",  rd_err, 1'b0);
    rd_exp.delete();
    tag_model.delete();
    p0_req = 0;
    repeat (2) tick();
    reset_n = 1;
    tick();
    za_valid = 1; za_data = 16'hBEEF;
    tick();
    za_valid = 0;
    settle();
    check("mr_fifo_flushed", rd_err, 1'b1);
    check("mr_no_rvalid", {p1_rvalid, p0_rvalid}, 2'b00);
    tick();

    check("sb_drained", rd_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
